// File: rtl/pv1000_pkg.sv
// Shared types and constants for the PV-1000 cartridge loader: FSM states,
// ROM window bounds, image-size encodings and the size-selection helpers.
package pv1000_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    MIR_RD,
    MIR_WAIT,
    MIR_WR,
    HOLD
  } state_t;

  localparam logic [15:0] ROM_WINDOW_END = 16'h7FFF;

  localparam logic [15:0] SIZE_8K  = 16'h2000;
  localparam logic [15:0] SIZE_16K = 16'h4000;
  localparam logic [15:0] SIZE_32K = 16'h8000;

  localparam logic [1:0] ROM_SIZE_8K  = 2'd0;
  localparam logic [1:0] ROM_SIZE_16K = 2'd1;
  localparam logic [1:0] ROM_SIZE_32K = 2'd2;

  // Smallest power-of-two image that still contains the highest written byte.
  function automatic logic [1:0] rom_size_for(input logic [15:0] last);
    if (last < SIZE_8K) begin
      return ROM_SIZE_8K;
    end else if (last < SIZE_16K) begin
      return ROM_SIZE_16K;
    end else begin
      return ROM_SIZE_32K;
    end
  endfunction

  function automatic logic [15:0] size_of(input logic [1:0] code);
    case (code)
      ROM_SIZE_8K:  return SIZE_8K;
      ROM_SIZE_16K: return SIZE_16K;
      default:      return SIZE_32K;
    endcase
  endfunction

endpackage

// File: rtl/pv1000_cart_loader.sv
// Cartridge loader: captures the HPS download into the 32 KiB ROM window,
// pads to a power-of-two size with 0xFF, mirrors it, then holds console reset.
module pv1000_cart_loader
  import pv1000_pkg::*;
#(
  parameter logic [7:0] CART_INDEX  = 8'd1,
  parameter int         HOLD_CYCLES = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ram_q,
  output logic [15:0] ram_a,
  output logic [7:0]  ram_d,
  output logic        ram_we,
  output logic        busy,
  output logic        console_reset,
  output logic [1:0]  rom_size,
  output logic        overflow
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_t      state_reg;
  logic        dl_prev_reg;
  logic [15:0] last_reg;
  logic [15:0] size_reg;
  logic [15:0] ptr_reg;
  logic [15:0] hold_cnt_reg;

  logic        dl_rise;
  logic        dl_fall;
  logic        cart_rise;
  logic        in_window;
  logic        wr_ok;
  logic [15:0] addr16;
  logic [15:0] last_next;
  logic [1:0]  fall_code;
  logic [15:0] fall_size;
  logic [15:0] pad_start;
  logic [15:0] size_mask;

  assign dl_rise   = ioctl_download & ~dl_prev_reg;
  assign dl_fall   = ~ioctl_download & dl_prev_reg;
  assign cart_rise = dl_rise && (ioctl_index == CART_INDEX);
  assign in_window = (ioctl_addr[24:15] == 10'd0);
  assign wr_ok     = ioctl_wr & in_window;
  assign addr16    = ioctl_addr[15:0];
  assign size_mask = size_reg - 16'd1;

  // A strobe coinciding with the download fall still counts toward the size.
  always_comb begin
    last_next = last_reg;
    if (wr_ok && (addr16 > last_reg)) begin
      last_next = addr16;
    end
    fall_code = rom_size_for(last_next);
    fall_size = size_of(fall_code);
    pad_start = last_next + 16'd1;
  end

  always_ff @(posedge clk_sys) begin
    dl_prev_reg <= ioctl_download;
    if (reset) begin
      state_reg     <= IDLE;
      ram_a         <= 16'd0;
      ram_d         <= 8'd0;
      ram_we        <= 1'b0;
      busy          <= 1'b0;
      console_reset <= 1'b1;
      rom_size      <= ROM_SIZE_8K;
      overflow      <= 1'b0;
      last_reg      <= 16'd0;
      size_reg      <= SIZE_8K;
      ptr_reg       <= 16'd0;
      hold_cnt_reg  <= 16'd0;
    end else begin
      ram_we <= 1'b0;
      if (cart_rise) begin
        // A new cartridge download restarts from any state.
        state_reg     <= LOAD;
        busy          <= 1'b1;
        console_reset <= 1'b1;
        last_reg      <= 16'd0;
        overflow      <= 1'b0;
        rom_size      <= ROM_SIZE_8K;
      end else begin
        case (state_reg)
          IDLE: begin
            busy          <= 1'b0;
            console_reset <= 1'b0;
          end

          LOAD: begin
            if (wr_ok) begin
              ram_we   <= 1'b1;
              ram_a    <= addr16;
              ram_d    <= ioctl_dout;
              last_reg <= last_next;
            end else if (ioctl_wr) begin
              overflow <= 1'b1;
            end
            if (dl_fall) begin
              rom_size <= fall_code;
              size_reg <= fall_size;
              if (pad_start != fall_size) begin
                ptr_reg   <= pad_start;
                state_reg <= PAD;
              end else if (fall_size != SIZE_32K) begin
                ptr_reg   <= fall_size;
                state_reg <= MIR_RD;
              end else begin
                hold_cnt_reg <= 16'd0;
                state_reg    <= HOLD;
              end
            end
          end

          PAD: begin
            ram_we <= 1'b1;
            ram_a  <= ptr_reg;
            ram_d  <= 8'hFF;
            if (ptr_reg == size_mask) begin
              if (size_reg != SIZE_32K) begin
                ptr_reg   <= size_reg;
                state_reg <= MIR_RD;
              end else begin
                hold_cnt_reg <= 16'd0;
                state_reg    <= HOLD;
              end
            end else begin
              ptr_reg <= ptr_reg + 16'd1;
            end
          end

          MIR_RD: begin
            ram_a     <= ptr_reg & size_mask;
            state_reg <= MIR_WAIT;
          end

          MIR_WAIT: begin
            state_reg <= MIR_WR;
          end

          MIR_WR: begin
            ram_we <= 1'b1;
            ram_a  <= ptr_reg;
            ram_d  <= ram_q;
            if (ptr_reg == ROM_WINDOW_END) begin
              hold_cnt_reg <= 16'd0;
              state_reg    <= HOLD;
            end else begin
              ptr_reg   <= ptr_reg + 16'd1;
              state_reg <= MIR_RD;
            end
          end

          HOLD: begin
            if (hold_cnt_reg == HOLD_LAST) begin
              busy          <= 1'b0;
              console_reset <= 1'b0;
              state_reg     <= IDLE;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 16'd1;
            end
          end

          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pv1000_cart_loader.md
# pv1000_cart_loader

Cartridge-image loader between the HPS download stream and the console's shared cartridge/RAM dual-port memory. It captures ioctl bytes for the cartridge menu entry into the 32 KiB ROM window at 0x0000–0x7FFF and pads a partial image to a power-of-two size with 0xFF. It then mirrors that image across the whole window and holds the console in reset until the memory image is complete.

## Interface
Parameters:
- CART_INDEX, 8'd1: ioctl_index value accepted as cartridge data; other indices are ignored.
- HOLD_CYCLES, 255: console-reset extension after the image completes.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download slot.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ram_q  in  8  port-A read data; 1-cycle registered read latency.
- ram_a  out  16  port-A address (registered).
- ram_d  out  8  port-A write data (registered).
- ram_we  out  1  port-A write enable (registered).
- busy  out  1  loader owns port A; the top-level muxes the RAM on it.
- console_reset  out  1  reset request ORed into the console reset.
- rom_size  out  2  0 = 8K, 1 = 16K, 2 = 32K.
- overflow  out  1  a byte addressed at or above 0x8000 was dropped.

## Operation
- States: IDLE, LOAD, PAD, MIR_RD, MIR_WAIT, MIR_WR, HOLD.
- IDLE: busy = 0, console_reset = 0.
- IDLE → LOAD: on an ioctl_download rise with ioctl_index == CART_INDEX.
  - Clears the max-address register, overflow, and rom_size.
- LOAD:
  - Each ioctl_wr with ioctl_addr < 0x8000 writes ioctl_dout to ram_a = ioctl_addr[15:0].
  - Each such write tracks last = max(last, addr).
  - A write with ioctl_addr ≥ 0x8000 is not written and sets overflow (sticky until the next load).
- Size rule, computed on the ioctl_download fall:
  - last < 0x2000 → 8K (size 0x2000).
  - last < 0x4000 → 16K.
  - otherwise → 32K.
  - A download with zero writes yields 8K.
- PAD: writes 0xFF at addresses last+1 … size−1, one per cycle; skipped if last+1 == size.
- MIRROR: for dst = size … 0x7FFF, src = dst & (size−1).
  - MIR_RD presents src, MIR_WAIT waits for the read, MIR_WR writes ram_q to dst.
  - 3 cycles per byte.
  - Skipped when size is 32K.
- HOLD: counts HOLD_CYCLES cycles, then returns to IDLE.
- busy = 1 and console_reset = 1 in every state except IDLE.
- New download rise with the matching index in any non-IDLE state: abort and re-enter LOAD; all registers are cleared as on entry.
- ioctl_download rise with a non-matching index: ignored in IDLE; in other states the sequence continues.
- Address arithmetic is 16-bit unsigned. The mirror loop ends when dst == 0x7FFF is written; dst never wraps past 0x8000.

## Timing
- Reset values: ram_a = 0, ram_d = 0, ram_we = 0, busy = 0, console_reset = 1 during reset (0 the cycle after), rom_size = 0, overflow = 0, state IDLE.
- LOAD write latency: ioctl_wr at cycle t → ram_we/ram_a/ram_d valid at t+1, for exactly one cycle.
- ioctl_wr strobes are not queued; back-to-back strobes on consecutive cycles are each written.
- Download fall at cycle t: size is latched at t+1 and PAD or MIRROR starts at t+1.
  - A simultaneous final ioctl_wr is written first and included in last.
- PAD: one write per cycle.
- MIR_RD at cycle n: ram_a = src from n+1; ram_q valid at n+2; ram_we = 1 at n+3 with ram_a = dst.
- Total mirror time: 3 × (0x8000 − size) cycles; 8K → 73728 cycles.
- HOLD → IDLE: busy and console_reset drop in the same cycle, HOLD_CYCLES cycles after the last mirror write.
- Reset mid-operation: immediate IDLE. A partially written image is left as-is; the next download reloads it.

## Structure
- Shared package pv1000_pkg:
  - state enum;
  - ROM_WINDOW_END = 16'h7FFF;
  - size constants 16'h2000 / 16'h4000 / 16'h8000;
  - rom_size encoding.
- Single module. The size/mask function is a package function, not a sub-module.

## Test plan
- Exactly 8K image, bytes = addr[7:0]: after completion, RAM[0x6123] == 0x23; rom_size = 0; mirror phase = 73728 cycles; console_reset falls 255 cycles after the last write.
- 12K image (last = 0x2FFF): RAM[0x3000..0x3FFF] == 0xFF; RAM[0x7000] == RAM[0x3000] == 0xFF; RAM[0x4ABC] == RAM[0x0ABC]; rom_size = 1.
- 32K image: no PAD, no MIRROR; HOLD starts the cycle after the download fall; 40K download sets overflow with RAM[0x0000] unchanged by addr 0x8000 bytes.
- ioctl_index = 0 download: no ram_we, busy stays 0.
- Second cartridge download started during MIR_WR: LOAD re-entered next cycle; overflow cleared; final image reflects the second file only.
- reset asserted mid-PAD: next cycle busy = 0, ram_we = 0, console_reset = 1; console_reset = 0 one cycle after reset releases.
